// File: rtl/cga_bus_pkg.sv
// cga_bus_pkg: shared types and helpers for the CGA bus master.
//   state_e       - bus cycle phases
//   strobe_sel_e  - which ISA strobe a cycle drives, encoded as {io, we}
//   CNT_W         - width of the phase and rdy-wait down-counters
//   strobe_lines  - active-low strobe vector {iow, ior, memw, memr}
//   cnt_param_ok  - range check for cycle-count parameters
package cga_bus_pkg;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    STB_MEMR = 2'b00,
    STB_MEMW = 2'b01,
    STB_IOR  = 2'b10,
    STB_IOW  = 2'b11
  } strobe_sel_e;

  localparam logic [3:0] STB_NONE = 4'hF;

  function automatic strobe_sel_e strobe_sel(input logic io, input logic we);
    return strobe_sel_e'({io, we});
  endfunction

  // Bit order {iow, ior, memw, memr}; exactly one bit is driven low.
  function automatic logic [3:0] strobe_lines(input strobe_sel_e sel);
    return ~(4'b0001 << sel);
  endfunction

  function automatic bit cnt_param_ok(input int val, input int lo);
    return (val >= lo) && (val <= CNT_MAX);
  endfunction

endpackage

// File: rtl/cga_bus_timer.sv
// cga_bus_timer: loadable down-counter with a zero flag.
//   clk, reset_l  - clock, synchronous active-low reset
//   load_i        - load load_val_i (wins over dec_i)
//   load_val_i    - value to load
//   dec_i         - decrement by one; holds at zero
//   zero_o        - count is zero
module cga_bus_timer
  import cga_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset_l,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cga_bus_master.sv
// cga_bus_master: turns the Next186 single-cycle req/ack port into an
// ISA-style strobe cycle for the CGA adapter, with setup, strobe-width and
// hold timing plus bus_rdy wait states bounded by a timeout.
//   clk, reset_l            - clock, synchronous active-low reset
//   cpu_req/we/io/addr/wdata - request, latched on acceptance in IDLE
//   cpu_ack/rdata/timeout   - one-cycle completion with read data and status
//   cpu_busy                - high whenever a cycle is in progress
//   bus_a, bus_d, bus_aen   - ISA address, write data, address enable
//   bus_ior_l .. bus_memw_l - active-low strobes
//   bus_out, bus_dir, bus_rdy - adapter read data, drive flag, ready
//
// state  | meaning
// IDLE   | waiting for cpu_req, aen high
// SETUP  | address/data/aen stable before the strobe
// STROBE | one strobe low; minimum width, then wait for bus_rdy or timeout
// HOLD   | strobe released, address/data/aen held
// DONE   | ack and timeout status issued on exit, aen released
module cga_bus_master
  import cga_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 24,
  parameter int HOLD_CYCLES   = 2,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_io,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_timeout,
  output logic [19:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_aen,
  input  logic [7:0]  bus_out,
  input  logic        bus_dir,
  input  logic        bus_rdy
);

  if (!cnt_param_ok(SETUP_CYCLES, 1) || !cnt_param_ok(STROBE_CYCLES, 2) ||
      !cnt_param_ok(HOLD_CYCLES, 1) || !cnt_param_ok(RDY_TIMEOUT, 1)) begin : g_bad_param
    $error("cga_bus_master: cycle-count parameter out of range");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  // Loaded with the full count: each waiting edge consumes one, so the
  // strobe ends on the edge after RDY_TIMEOUT extra cycles.
  localparam logic [CNT_W-1:0] RDY_LD    = CNT_W'(RDY_TIMEOUT);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic [19:0] bus_a_q, bus_a_d;
  logic [7:0]  bus_d_q, bus_d_d;
  logic [3:0]  stb_l_q, stb_l_d;
  logic        aen_q, aen_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        to_q, to_d;
  logic [7:0]  rdata_q, rdata_d;

  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             wt_load, wt_dec, wt_zero;

  logic dir_unused;
  assign dir_unused = bus_dir;

  cga_bus_timer u_phase_tmr (
    .clk        (clk),
    .reset_l    (reset_l),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .zero_o     (ph_zero)
  );

  cga_bus_timer u_wait_tmr (
    .clk        (clk),
    .reset_l    (reset_l),
    .load_i     (wt_load),
    .load_val_i (RDY_LD),
    .dec_i      (wt_dec),
    .zero_o     (wt_zero)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    io_d    = io_q;
    bus_a_d = bus_a_q;
    bus_d_d = bus_d_q;
    stb_l_d = stb_l_q;
    aen_d   = aen_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    ph_load = 1'b0;
    ph_val  = '0;
    ph_dec  = 1'b0;
    wt_load = 1'b0;
    wt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          io_d    = cpu_io;
          bus_a_d = cpu_addr;
          bus_d_d = cpu_wdata;
          aen_d   = 1'b0;
          busy_d  = 1'b1;
          to_d    = 1'b0;
          ph_load = 1'b1;
          ph_val  = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ph_zero) begin
          stb_l_d = strobe_lines(strobe_sel(io_q, we_q));
          ph_load = 1'b1;
          ph_val  = STROBE_LD;
          wt_load = 1'b1;
          state_d = ST_STROBE;
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (!ph_zero) begin
          ph_dec = 1'b1;
        end else if (bus_rdy) begin
          stb_l_d = STB_NONE;
          if (!we_q) begin
            rdata_d = bus_out;
          end
          ph_load = 1'b1;
          ph_val  = HOLD_LD;
          state_d = ST_HOLD;
        end else if (wt_zero) begin
          stb_l_d = STB_NONE;
          rdata_d = 8'hFF;
          to_d    = 1'b1;
          ph_load = 1'b1;
          ph_val  = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          wt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ph_zero) begin
          state_d = ST_DONE;
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_DONE: begin
        ack_d   = 1'b1;
        aen_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        stb_l_d = STB_NONE;
        aen_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      bus_a_q <= '0;
      bus_d_q <= '0;
      stb_l_q <= STB_NONE;
      aen_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      io_q    <= io_d;
      bus_a_q <= bus_a_d;
      bus_d_q <= bus_d_d;
      stb_l_q <= stb_l_d;
      aen_q   <= aen_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_ack     = ack_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_busy    = busy_q;
  assign cpu_timeout = to_q;
  assign bus_a       = bus_a_q;
  assign bus_d       = bus_d_q;
  assign bus_aen     = aen_q;
  assign bus_memr_l  = stb_l_q[0];
  assign bus_memw_l  = stb_l_q[1];
  assign bus_ior_l   = stb_l_q[2];
  assign bus_iow_l   = stb_l_q[3];

endmodule

// File: tb/tb_cga_bus_master.sv
module tb_cga_bus_master;

  localparam int SETUP = 2;
  localparam int STB   = 24;
  localparam int HOLD  = 2;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        cpu_req, cpu_we, cpu_io;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_busy, cpu_timeout;
  logic [7:0]  cpu_rdata;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
  logic [7:0]  bus_out;
  logic        bus_dir, bus_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cga_bus_master #(
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STB),
    .HOLD_CYCLES   (HOLD),
    .RDY_TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_io      (cpu_io),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_busy    (cpu_busy),
    .cpu_timeout (cpu_timeout),
    .bus_a       (bus_a),
    .bus_d       (bus_d),
    .bus_ior_l   (bus_ior_l),
    .bus_iow_l   (bus_iow_l),
    .bus_memr_l  (bus_memr_l),
    .bus_memw_l  (bus_memw_l),
    .bus_aen     (bus_aen),
    .bus_out     (bus_out),
    .bus_dir     (bus_dir),
    .bus_rdy     (bus_rdy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction. Entered and left at #1 after a rising edge; the request
  // is accepted on the next edge. w = cycles bus_rdy stays low past the
  // minimum strobe width (w > TMO means it never comes back).
  task automatic run_txn(input logic we, input logic io, input logic [19:0] addr,
                         input logic [7:0] wd, input logic [7:0] bo, input int w,
                         input bit keep, input string name);
    int  low[4];
    int  exp_stb, exp_lat, exp_idx, cyc, lat, stb_cnt, aen_low, busy_hi, a_bad, d_bad;
    bit  exp_to, got_ack;
    logic [7:0] rd;
    logic to, ack_aen;

    exp_to  = (w > TMO);
    exp_stb = STB + (exp_to ? TMO : w);
    exp_lat = SETUP + exp_stb + HOLD + 1;
    // low[] index: 0 ior, 1 iow, 2 memr, 3 memw
    exp_idx = io ? (we ? 1 : 0) : (we ? 3 : 2);

    low = '{default: 0};
    aen_low = 0; busy_hi = 0; a_bad = 0; d_bad = 0;
    got_ack = 0; cyc = 0; lat = -1; rd = 'x; to = 'x; ack_aen = 'x;

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_io    = io;
    cpu_addr  = addr;
    cpu_wdata = wd;
    bus_out   = bo;
    bus_rdy   = (w == 0);

    while (!got_ack && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({name, "_ack_idle"}, cpu_ack, 0);
      if (!bus_ior_l)  low[0]++;
      if (!bus_iow_l)  low[1]++;
      if (!bus_memr_l) low[2]++;
      if (!bus_memw_l) low[3]++;
      stb_cnt = low[0] + low[1] + low[2] + low[3];
      if (!bus_aen) begin
        aen_low++;
        if (bus_a !== addr) a_bad++;
        if (bus_d !== wd)   d_bad++;
      end
      if (cpu_busy) busy_hi++;
      if (w > 0 && stb_cnt == STB + w) bus_rdy = 1'b1;
      if (cyc == 3) begin
        cpu_addr  = 20'($urandom);
        cpu_wdata = 8'($urandom);
        cpu_we    = 1'($urandom);
        cpu_io    = 1'($urandom);
      end
      if (cpu_ack) begin
        got_ack = 1;
        lat     = cyc - 1;
        rd      = cpu_rdata;
        to      = cpu_timeout;
        ack_aen = bus_aen;
      end
    end

    check({name, "_got_ack"}, got_ack, 1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_strobe_len"}, low[exp_idx], exp_stb);
    check({name, "_other_strobes"}, stb_cnt - low[exp_idx], 0);
    check({name, "_aen_low"}, aen_low, exp_lat);
    check({name, "_busy_len"}, busy_hi, exp_lat);
    check({name, "_addr_stable"}, a_bad, 0);
    check({name, "_data_stable"}, d_bad, 0);
    check({name, "_timeout"}, to, exp_to);
    check({name, "_aen_at_ack"}, ack_aen, 1);
    if (exp_to)  check({name, "_rdata_tmo"}, rd, 8'hFF);
    else if (!we) check({name, "_rdata"}, rd, bo);

    bus_rdy = 1'b1;
    if (!keep) begin
      cpu_req = 1'b0;
      @(posedge clk); #1;
      check({name, "_ack_single"}, cpu_ack, 0);
      check({name, "_idle_busy"}, cpu_busy, 0);
      check({name, "_idle_bus_d"}, bus_d, wd);
      check({name, "_idle_aen"}, bus_aen, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, sel, acks;

    reset_l   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_io    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    bus_out   = '0;
    bus_dir   = 1'b0;
    bus_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}, 4'hF);
    check("rst_aen", bus_aen, 1);
    check("rst_bus_a", bus_a, 0);
    check("rst_bus_d", bus_d, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_busy", cpu_busy, 0);
    check("rst_timeout", cpu_timeout, 0);
    check("rst_rdata", cpu_rdata, 0);
    reset_l = 1'b1;
    @(posedge clk); #1;
    check("idle_no_req", cpu_busy, 0);

    run_txn(1'b1, 1'b1, 20'h003D8, 8'h29, 8'h00, 0, 0, "io_wr");
    run_txn(1'b0, 1'b0, 20'hB8001, 8'h00, 8'h5A, 0, 0, "mem_rd");
    run_txn(1'b1, 1'b0, 20'hB8123, 8'hC3, 8'h11, 10, 0, "mem_wr_wait");
    run_txn(1'b0, 1'b0, 20'hB8456, 8'h00, 8'h77, 300, 0, "rdy_stuck");
    run_txn(1'b0, 1'b1, 20'h003DA, 8'h00, 8'h3C, TMO, 0, "rdy_last");

    // reset in the middle of an IO read strobe
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_io   = 1'b1;
    cpu_addr = 20'h003DA;
    bus_rdy  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    check("mid_rst_ior_low", bus_ior_l, 0);
    reset_l = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_strobes", {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}, 4'hF);
    check("mid_rst_aen", bus_aen, 1);
    check("mid_rst_busy", cpu_busy, 0);
    reset_l = 1'b1;
    cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    check("mid_rst_idle", cpu_busy, 0);

    // request held across two transactions
    run_txn(1'b1, 1'b1, 20'h003D9, 8'h15, 8'h00, 0, 1, "held_a");
    run_txn(1'b0, 1'b0, 20'hB8F00, 8'h00, 8'hA5, 0, 0, "held_b");

    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       w = 0;
        1:       w = $urandom_range(1, TMO - 1);
        2:       w = TMO;
        3:       w = TMO + 1;
        default: w = 200;
      endcase
      run_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
              w, 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
